// File: rtl/proc_hier_top.sv
// ---------------------------------------------------------------------------
// proc_hier_top
//   Single-cycle 16-bit processor with eight general registers (R0 is an
//   ordinary register), a 256x16 instruction memory loaded through a write
//   port, and a 256x16 data memory. Each instruction is fetched, decoded and
//   executed combinationally; registers, memories and PC update on the rising
//   clock edge. HALT stops execution until reset.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   imem_we        instruction-memory write enable (honoured at all times)
//   imem_waddr     instruction-memory word index to write
//   imem_wdata     instruction word to write
//   pc             byte address of the current instruction
//   inst           current instruction word
//   reg_write      a register is written this cycle
//   write_register destination register
//   write_data     value written to the register
//   mem_read       LD executing
//   mem_write      ST executing
//   mem_address    data address, R[rs] + sext(imm6)
//   mem_data       store data, R[rd]
//   halt           HALT executing or processor halted
//   cycle_count    cycles since reset release (wraps at 2^32)
// ---------------------------------------------------------------------------
module proc_hier_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_we,
    input  logic [7:0]  imem_waddr,
    input  logic [15:0] imem_wdata,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        reg_write,
    output logic [2:0]  write_register,
    output logic [15:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data,
    output logic        halt,
    output logic [31:0] cycle_count
);

    typedef enum logic [3:0] {
        OP_HALT = 4'h0, OP_NOP  = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_SLL  = 4'h7,
        OP_ADDI = 4'h8, OP_LD   = 4'h9, OP_ST   = 4'hA, OP_LI   = 4'hB,
        OP_BEQZ = 4'hC, OP_BNEZ = 4'hD, OP_J    = 4'hE, OP_JAL  = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // Architectural state
    logic [15:0] imem_q [256];
    logic [15:0] dmem_q [256];
    logic [15:0] rf_q   [8];
    logic [15:0] pc_q, pc_d;
    logic [31:0] cycle_q;
    state_e      state_q;

    // Decode fields
    opcode_e     op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] imm6_sx, imm9_sx, imm12_sx;
    logic [15:0] rs_val, rt_val, rd_val;
    logic [15:0] pc_plus2;
    logic [15:0] alu_res;
    logic        exec;
    logic        br_taken;

    // Fetch and decode
    always_comb begin
        inst     = imem_q[pc_q[8:1]];
        op       = opcode_e'(inst[15:12]);
        rd       = inst[11:9];
        rs       = inst[8:6];
        rt       = inst[5:3];
        imm6_sx  = {{10{inst[5]}}, inst[5:0]};
        imm9_sx  = {{7{inst[8]}},  inst[8:0]};
        imm12_sx = {{4{inst[11]}}, inst[11:0]};
        rs_val   = rf_q[rs];
        rt_val   = rf_q[rt];
        rd_val   = rf_q[rd];
        pc_plus2 = pc_q + 16'd2;
    end

    // Execute: ALU, memory interface, write-back selection and next PC
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        alu_res        = 16'h0000;
        reg_write      = 1'b0;
        write_register = rd;
        write_data     = 16'h0000;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        br_taken       = 1'b0;
        pc_d           = pc_plus2;

        // Halt is visible in the same cycle HALT is fetched; reset masks it.
        halt = !rst && ((state_q == ST_HALTED) || (op == OP_HALT));
        exec = !rst && !halt;

        mem_address = rs_val + imm6_sx;
        mem_data    = rd_val;

        unique case (op)
            OP_ADD:  alu_res = rs_val + rt_val;
            OP_SUB:  alu_res = rs_val - rt_val;
            OP_AND:  alu_res = rs_val & rt_val;
            OP_OR:   alu_res = rs_val | rt_val;
            OP_XOR:  alu_res = rs_val ^ rt_val;
            OP_SLL:  alu_res = rs_val << rt_val[3:0];
            OP_ADDI: alu_res = rs_val + imm6_sx;
            default: alu_res = 16'h0000;
        endcase

        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_ADDI: begin
                reg_write  = exec;
                write_data = alu_res;
            end
            OP_LD: begin
                reg_write  = exec;
                mem_read   = exec;
                write_data = dmem_q[mem_address[8:1]];
            end
            OP_ST: begin
                mem_write = exec;
            end
            OP_LI: begin
                reg_write  = exec;
                write_data = imm9_sx;
            end
            OP_BEQZ: begin
                br_taken = (rd_val == 16'h0000);
            end
            OP_BNEZ: begin
                br_taken = (rd_val != 16'h0000);
            end
            OP_J: begin
                pc_d = pc_plus2 + {imm12_sx[14:0], 1'b0};
            end
            OP_JAL: begin
                reg_write      = exec;
                write_register = 3'd7;
                write_data     = pc_plus2;
                pc_d           = pc_plus2 + {imm12_sx[14:0], 1'b0};
            end
            default: begin
                // HALT and NOP: nothing beyond the default PC step
            end
        endcase

        if (br_taken) begin
            pc_d = pc_plus2 + {imm9_sx[14:0], 1'b0};
        end
        if (halt) begin
            pc_d = pc_q;
        end

        pc          = pc_q;
        cycle_count = cycle_q;
    end

    // Core state: PC, register file, run/halted state and cycle counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            pc_q    <= 16'h0000;
            cycle_q <= 32'h0000_0000;
            state_q <= ST_RUN;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            pc_q    <= pc_d;
            cycle_q <= cycle_q + 32'd1;
            if (op == OP_HALT) begin
                state_q <= ST_HALTED;
            end
            if (reg_write) begin
                rf_q[write_register] <= write_data;
            end
        end
    end

    // NOTE: the memories carry no reset; their contents must survive rst,
    // and a reset port would prevent mapping them onto RAM macros.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write) begin
            dmem_q[mem_address[8:1]] <= mem_data;
        end
    end

endmodule

// File: tb/tb_proc_hier_top.sv
// ---------------------------------------------------------------------------
// tb_proc_hier_top
//   Self-checking bench for proc_hier_top. Each scenario loads a short
//   program while reset is held, pushes the expected per-cycle behaviour of
//   every instruction onto a scoreboard queue, releases reset and compares
//   the DUT outputs against the popped entries on each falling edge.
// ---------------------------------------------------------------------------
module tb_proc_hier_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = 8'h00;
    logic [15:0] imem_wdata = 16'h0000;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        reg_write;
    logic [2:0]  write_register;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        halt;
    logic [31:0] cycle_count;

    proc_hier_top dut (
        .clk            (clk),
        .rst            (rst),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc             (pc),
        .inst           (inst),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .halt           (halt),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        rw;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        mr;
        logic        mw;
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic        halt;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] prog [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [15:0] NOP_W  = 16'h1000;
    localparam logic [15:0] HALT_W = 16'h0000;

    // Instruction encoders
    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i6(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [15:0] enc_i9(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [8:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [11:0] imm);
        return {op, imm};
    endfunction

    // Scoreboard producers
    task automatic push(input logic [15:0] epc, input logic rw, input logic [2:0] wreg,
                        input logic [15:0] wdata, input logic mr, input logic mw,
                        input logic [15:0] maddr, input logic [15:0] mdata, input logic h);
        exp_t e;
        e.pc = epc; e.rw = rw; e.wreg = wreg; e.wdata = wdata;
        e.mr = mr; e.mw = mw; e.maddr = maddr; e.mdata = mdata; e.halt = h;
        sb_q.push_back(e);
    endtask

    task automatic exp_none(input logic [15:0] epc);
        push(epc, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic exp_reg(input logic [15:0] epc, input logic [2:0] r, input logic [15:0] d);
        push(epc, 1'b1, r, d, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic exp_st(input logic [15:0] epc, input logic [15:0] a, input logic [15:0] d);
        push(epc, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic exp_ld(input logic [15:0] epc, input logic [15:0] a,
                          input logic [2:0] r, input logic [15:0] d);
        push(epc, 1'b1, r, d, 1'b1, 1'b0, a, 16'h0, 1'b0);
    endtask

    task automatic exp_halt(input logic [15:0] epc);
        push(epc, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    // Scoreboard consumer: one entry per executed cycle, sampled mid-cycle
    task automatic sb_drain(input string name);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            n_checks++;
            if ({pc, reg_write, mem_read, mem_write, halt} !== {e.pc, e.rw, e.mr, e.mw, e.halt}) begin
                n_fail++;
                $display("FAIL %s ctrl: got pc=%h rw=%b mr=%b mw=%b halt=%b, want pc=%h rw=%b mr=%b mw=%b halt=%b",
                         name, pc, reg_write, mem_read, mem_write, halt,
                         e.pc, e.rw, e.mr, e.mw, e.halt);
            end
            if (e.rw) begin
                n_checks++;
                if ({write_register, write_data} !== {e.wreg, e.wdata}) begin
                    n_fail++;
                    $display("FAIL %s wb @pc=%h: got R%0d=%h, want R%0d=%h",
                             name, e.pc, write_register, write_data, e.wreg, e.wdata);
                end
            end
            if (e.mr || e.mw) begin
                n_checks++;
                if (mem_address !== e.maddr) begin
                    n_fail++;
                    $display("FAIL %s addr @pc=%h: got %h, want %h", name, e.pc, mem_address, e.maddr);
                end
            end
            if (e.mw) begin
                n_checks++;
                if (mem_data !== e.mdata) begin
                    n_fail++;
                    $display("FAIL %s stdata @pc=%h: got %h, want %h", name, e.pc, mem_data, e.mdata);
                end
            end
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = NOP_W;
    endtask

    // Holds reset (well over two cycles) while writing the program image
    task automatic load_program();
        rst = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            imem_we    = 1'b1;
            imem_waddr = 8'(i);
            imem_wdata = prog[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = enc_i9(4'hB, 3'd1, 9'h005);   // LI R1,5: would write if not masked
        load_program();
        n_checks++;
        if (pc !== 16'h0000 || cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h cycles=%0d, want pc=0000 cycles=0", pc, cycle_count);
        end
        n_checks++;
        if ({reg_write, mem_read, mem_write, halt} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mask: got rw/mr/mw/halt=%b%b%b%b, want 0000",
                     reg_write, mem_read, mem_write, halt);
        end
        release_rst();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (cycle_count !== 32'(k) || pc !== 16'(2 * k)) begin
                n_fail++;
                $display("FAIL reset_count[%0d]: got cycles=%0d pc=%h, want cycles=%0d pc=%h",
                         k, cycle_count, pc, k, 2 * k);
            end
        end
    endtask

    task automatic test_alu();
        clear_prog();
        prog[0] = enc_i9(4'hB, 3'd1, 9'h005);           // LI  R1,5
        prog[1] = enc_i9(4'hB, 3'd2, 9'h1FD);           // LI  R2,-3
        prog[2] = enc_r(4'h2, 3'd3, 3'd1, 3'd2);        // ADD R3,R1,R2
        prog[3] = enc_r(4'h3, 3'd4, 3'd1, 3'd2);        // SUB R4,R1,R2
        prog[4] = enc_r(4'h7, 3'd5, 3'd1, 3'd1);        // SLL R5,R1,R1
        prog[5] = enc_r(4'h4, 3'd6, 3'd1, 3'd2);        // AND R6,R1,R2
        prog[6] = enc_r(4'h5, 3'd6, 3'd1, 3'd2);        // OR  R6,R1,R2
        prog[7] = enc_r(4'h6, 3'd6, 3'd1, 3'd2);        // XOR R6,R1,R2
        load_program();
        exp_reg(16'h0000, 3'd1, 16'h0005);
        exp_reg(16'h0002, 3'd2, 16'hFFFD);
        exp_reg(16'h0004, 3'd3, 16'h0002);
        exp_reg(16'h0006, 3'd4, 16'h0008);
        exp_reg(16'h0008, 3'd5, 16'h00A0);
        exp_reg(16'h000A, 3'd6, 16'h0005);
        exp_reg(16'h000C, 3'd6, 16'hFFFD);
        exp_reg(16'h000E, 3'd6, 16'hFFF8);
        exp_none(16'h0010);
        release_rst();
        sb_drain("alu");
    endtask

    task automatic test_memory();
        clear_prog();
        prog[0] = enc_i9(4'hB, 3'd1, 9'h010);           // LI   R1,0x10
        prog[1] = enc_i9(4'hB, 3'd2, 9'h055);           // LI   R2,0x55
        prog[2] = enc_i6(4'hA, 3'd2, 3'd1, 6'd2);       // ST   R2,R1,2
        prog[3] = enc_i6(4'h9, 3'd4, 3'd1, 6'd2);       // LD   R4,R1,2
        prog[4] = enc_i9(4'hB, 3'd3, 9'h1FF);           // LI   R3,-1
        prog[5] = enc_i6(4'hA, 3'd2, 3'd3, 6'd3);       // ST   R2,R3,3 -> wraps to 0x0002
        prog[6] = enc_i6(4'h9, 3'd6, 3'd0, 6'd2);       // LD   R6,R0,2
        prog[7] = enc_i6(4'h8, 3'd5, 3'd1, 6'h3F);      // ADDI R5,R1,-1
        load_program();
        exp_reg(16'h0000, 3'd1, 16'h0010);
        exp_reg(16'h0002, 3'd2, 16'h0055);
        exp_st (16'h0004, 16'h0012, 16'h0055);
        exp_ld (16'h0006, 16'h0012, 3'd4, 16'h0055);
        exp_reg(16'h0008, 3'd3, 16'hFFFF);
        exp_st (16'h000A, 16'h0002, 16'h0055);
        exp_ld (16'h000C, 16'h0002, 3'd6, 16'h0055);
        exp_reg(16'h000E, 3'd5, 16'h000F);
        release_rst();
        sb_drain("memory");
    endtask

    task automatic test_branch();
        clear_prog();
        prog[8]  = enc_i9(4'hC, 3'd0, 9'h002);          // 0x10 BEQZ R0,+2 -> 0x16
        prog[11] = enc_i9(4'hD, 3'd0, 9'h005);          // 0x16 BNEZ R0 (not taken)
        prog[12] = enc_i9(4'hB, 3'd1, 9'h001);          // 0x18 LI   R1,1
        prog[13] = enc_i9(4'hD, 3'd1, 9'h002);          // 0x1A BNEZ R1,+2 -> 0x20
        prog[16] = enc_j (4'hF, 12'hFFF);               // 0x20 JAL  -1 -> 0x20
        load_program();
        for (int i = 0; i < 8; i++) exp_none(16'(2 * i));
        exp_none(16'h0010);
        exp_none(16'h0016);
        exp_reg (16'h0018, 3'd1, 16'h0001);
        exp_none(16'h001A);
        exp_reg (16'h0020, 3'd7, 16'h0022);
        exp_reg (16'h0020, 3'd7, 16'h0022);
        release_rst();
        sb_drain("branch");
    endtask

    task automatic test_halt();
        clear_prog();
        prog[0] = enc_i9(4'hB, 3'd1, 9'h007);           // LI R1,7
        prog[2] = enc_i9(4'hB, 3'd2, 9'h003);           // LI R2,3
        prog[4] = HALT_W;                               // 0x08 HALT
        prog[5] = enc_i9(4'hB, 3'd3, 9'h009);           // must never execute
        load_program();
        exp_reg (16'h0000, 3'd1, 16'h0007);
        exp_none(16'h0002);
        exp_reg (16'h0004, 3'd2, 16'h0003);
        exp_none(16'h0006);
        for (int i = 0; i < 6; i++) exp_halt(16'h0008);
        release_rst();
        sb_drain("halt");
        // Last drained sample was cycle 9; three more cycles while halted
        repeat (3) @(negedge clk);
        n_checks++;
        if (cycle_count !== 32'd12 || pc !== 16'h0008 || halt !== 1'b1 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_hold: got cycles=%0d pc=%h halt=%b rw=%b, want cycles=12 pc=0008 halt=1 rw=0",
                     cycle_count, pc, halt, reg_write);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_rst_mask: got halt=%b, want 0", halt);
        end
        exp_reg (16'h0000, 3'd1, 16'h0007);
        exp_none(16'h0002);
        release_rst();
        sb_drain("halt_restart");
    endtask

    task automatic test_overflow();
        clear_prog();
        prog[0] = enc_i9(4'hB, 3'd1, 9'h1FF);           // LI   R1,-1
        prog[1] = enc_i6(4'h8, 3'd1, 3'd1, 6'd1);       // ADDI R1,R1,1
        prog[2] = enc_r (4'h2, 3'd2, 3'd1, 3'd1);       // ADD  R2,R1,R1
        prog[3] = enc_i9(4'hB, 3'd3, 9'h100);           // LI   R3,-256
        prog[4] = enc_r (4'h2, 3'd4, 3'd3, 3'd3);       // ADD  R4,R3,R3
        load_program();
        exp_reg (16'h0000, 3'd1, 16'hFFFF);
        exp_reg (16'h0002, 3'd1, 16'h0000);
        exp_reg (16'h0004, 3'd2, 16'h0000);
        exp_reg (16'h0006, 3'd3, 16'hFF00);
        exp_reg (16'h0008, 3'd4, 16'hFE00);
        exp_none(16'h000A);
        release_rst();
        sb_drain("overflow");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_branch();
        test_halt();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/proc_hier_top.md
PROC_HIER_TOP -- requirements
Module: proc_hier_top

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have the ports below (clock and reset first):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_we  in  1  instruction-memory write enable.
- imem_waddr  in  8  instruction-memory word index to write.
- imem_wdata  in  16  instruction word to write.
- pc  out  16  byte address of the current instruction.
- inst  out  16  current instruction word.
- reg_write  out  1  a register is written this cycle.
- write_register  out  3  destination register.
- write_data  out  16  value written to the register.
- mem_read  out  1  LD executing.
- mem_write  out  1  ST executing.
- mem_address  out  16  data address (rs + sext(imm6)).
- mem_data  out  16  store data, R[rd].
- halt  out  1  HALT executing or processor halted.
- cycle_count  out  32  cycles since reset release.

Function
REQ-003 SHALL be a single-cycle 16-bit processor with eight 16-bit registers R0-R7; R0 is an ordinary register.
REQ-004 SHALL hold 256x16 instruction memory indexed by pc[8:1]; an imem_we write lands at the clock edge and is readable next cycle.
REQ-005 SHALL hold 256x16 data memory indexed by address[8:1]; bit 0 and bits 15:9 are ignored.
REQ-006 SHALL read inst and registers combinationally; register, memory and PC writes occur at the rising edge.
REQ-007 SHALL use these encodings: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm6=[5:0], imm9=[8:0], imm12=[11:0]; all immediates are sign-extended.
REQ-008 SHALL decode these opcodes:
- 0 HALT
- 1 NOP
- 2 ADD rd=rs+rt
- 3 SUB rd=rs-rt
- 4 AND
- 5 OR
- 6 XOR
- 7 SLL rd=rs<<rt[3:0]
- 8 ADDI rd=rs+imm6
- 9 LD rd=M[rs+imm6]
- A ST M[rs+imm6]=R[rd]
- B LI rd=imm9
- C BEQZ: branch if R[rd]==0
- D BNEZ: branch if R[rd]!=0
- E J
- F JAL: R7=pc+2, then jump
REQ-009 SHALL wrap all arithmetic modulo 2^16 and SHALL NOT flag or trap.
REQ-010 SHALL compute the next PC as follows:
- default: pc+2.
- taken branch: pc+2+(imm9<<1).
- J/JAL: pc+2+(imm12<<1).
- all wrap modulo 2^16.
REQ-011 SHALL drive reg_write=1 only for opcodes 2-9, B and F.
REQ-012 SHALL drive write_register=rd for register-writing ops, except JAL, which drives 7.
REQ-013 SHALL drive mem_read=1 only for LD and mem_write=1 only for ST.
REQ-014 SHALL drive mem_address and mem_data every cycle; their values are meaningful only when mem_read or mem_write is 1.
REQ-015 SHALL, on HALT, assert halt combinationally, suppress all writes and latch a halted state.
REQ-016 SHALL, while halted, hold PC, keep halt=1 and write nothing until rst.
REQ-017 SHALL increment cycle_count by 1 every cycle rst is low, including halted cycles; it wraps at 2^32.
REQ-018 SHALL write imem even while halted or in reset.

Reset
REQ-019 SHALL, while rst=1 at an edge, set pc=0, all registers=0, cycle_count=0 and clear the halted state.
REQ-020 SHALL force reg_write=mem_read=mem_write=halt=0 while rst=1.
REQ-021 SHALL leave data and instruction memory unchanged by reset.
REQ-022 SHALL, when rst is asserted mid-program, abandon the current instruction without writing it; execution restarts at pc 0 after release.

Verification
REQ-023 Reset: hold rst 2 cycles -> pc=0x0000, cycle_count=0, reg_write=0; after release, cycle_count increments by 1 per cycle.
REQ-024 ALU: LI R1,5; LI R2,-3; ADD R3,R1,R2; SUB R4,R1,R2; SLL R5,R1,R1 -> write_data 0x0005, 0xFFFD, 0x0002, 0x0008, 0x00A0.
REQ-025 Memory: LI R1,0x10; LI R2,0x55; ST R2,R1,2; LD R4,R1,2 -> ST cycle: mem_write=1, mem_address=0x0012, mem_data=0x0055; LD cycle: mem_read=1, write_register=4, write_data=0x0055.
REQ-026 Branch/jump: BEQZ R0 (R0=0) with imm9=2 at pc 0x0010 -> next pc=0x0016; BNEZ R0 -> pc+2; JAL imm12=-1 at pc 0x0020 -> R7=0x0022, next pc=0x0020.
REQ-027 Halt: HALT at pc 0x0008 -> halt=1; pc stays 0x0008 for 5+ cycles with no writes while cycle_count keeps counting; rst then restarts at pc 0.
REQ-028 Overflow: LI R1,-1; ADDI R1,R1,1 -> write_data=0x0000, no other effect.
